// File: rtl/uart_rx_sampler_if.sv
// rtl/uart_rx_sampler_if.sv - byte holding-register handshake between UART receiver and consumer
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_sampler_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 frame_err;
    logic                 overrun;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;

    modport master (
        output rx_data, rx_valid, frame_err, overrun, parity_err,
        input  rx_ack
    );
    modport slave (
        input  rx_data, rx_valid, frame_err, overrun, parity_err,
        output rx_ack
    );
`else
    modport master (
        output rx_data, rx_valid, frame_err, overrun,
        input  rx_ack
    );
    modport slave (
        input  rx_data, rx_valid, frame_err, overrun,
        output rx_ack
    );
`endif
endinterface

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - oversampling 8N1 UART receiver with valid/ack holding register
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx_sampler #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic                  smp_tick,
    input  logic                  rx,
    output logic                  busy,
    uart_rx_sampler_if.master     host
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CTR_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CTR_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, BREAK
`ifdef UART_RX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t               state, state_next;
    logic [CW-1:0]        ctr, ctr_next;
    logic [BW-1:0]        bitcnt, bitcnt_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 rx_meta, rx_s;
    logic                 load, ferr;
`ifdef UART_RX_PARITY_EN
    logic                 perr;
`endif

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state  <= IDLE;
            ctr    <= '0;
            bitcnt <= '0;
            shift  <= '0;
        end else begin
            state  <= state_next;
            ctr    <= ctr_next;
            bitcnt <= bitcnt_next;
            shift  <= shift_next;
        end
    end

    always_comb begin
        state_next  = state;
        ctr_next    = ctr;
        bitcnt_next = bitcnt;
        shift_next  = shift;
        load        = 1'b0;
        ferr        = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr        = 1'b0;
`endif
        if (smp_tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_next = START;
                        ctr_next   = '0;
                    end
                end
                START: begin
                    if (ctr == CTR_MID) begin
                        if (rx_s) begin
                            state_next = IDLE;
                        end else begin
                            state_next  = DATA;
                            ctr_next    = '0;
                            bitcnt_next = '0;
                        end
                    end else begin
                        ctr_next = ctr + 1'b1;
                    end
                end
                DATA: begin
                    if (ctr == CTR_LAST) begin
                        shift_next  = {rx_s, shift[DATA_BITS-1:1]};
                        bitcnt_next = bitcnt + 1'b1;
                        ctr_next    = '0;
                        if (bitcnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end
                    end else begin
                        ctr_next = ctr + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (ctr == CTR_LAST) begin
                        perr       = ^{shift, rx_s};
                        ctr_next   = '0;
                        state_next = STOP;
                    end else begin
                        ctr_next = ctr + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (ctr == CTR_LAST) begin
                        ctr_next = '0;
                        if (rx_s) begin
                            load       = 1'b1;
                            state_next = IDLE;
                        end else begin
                            ferr       = 1'b1;
                            state_next = BREAK;
                        end
                    end else begin
                        ctr_next = ctr + 1'b1;
                    end
                end
                // Hold here until the line goes high so a stuck-low line cannot retrigger.
                BREAK: begin
                    if (rx_s) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // A fresh load always wins over a same-cycle ack; overrun only when the old byte was unread.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            host.rx_data   <= '0;
            host.rx_valid  <= 1'b0;
            host.overrun   <= 1'b0;
            host.frame_err <= 1'b0;
        end else begin
            host.frame_err <= ferr;
            if (load) begin
                host.rx_data  <= shift;
                host.rx_valid <= 1'b1;
                if (host.rx_valid && !host.rx_ack) begin
                    host.overrun <= 1'b1;
                end else if (host.rx_valid && host.rx_ack) begin
                    host.overrun <= 1'b0;
                end
            end else if (host.rx_ack && host.rx_valid) begin
                host.rx_valid <= 1'b0;
                host.overrun  <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge sys_clk) begin
        if (reset) host.parity_err <= 1'b0;
        else       host.parity_err <= perr;
    end
`endif

    assign busy = (state != IDLE);

endmodule
